// File: rtl/video_stream_unpacker_if.sv
// Packed 24-bit RGB stream in, one pixel per handshake out.
// No logic of its own; bundles the stream side and the pixel side.
// Stream side: tvalid/tready. Pixel side: pix_valid/pix_ready.
interface video_stream_unpacker_if;
  logic [31:0] in_stream_tdata;
  logic [3:0]  in_stream_tkeep;
  logic        in_stream_tlast;
  logic        in_stream_tuser;
  logic        in_stream_tvalid;
  logic        in_stream_tready;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready;

  // Producer of the stream and consumer of the pixels
  modport master (
    output in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser, in_stream_tvalid,
    input  in_stream_tready,
    input  pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, pix_valid,
    output pix_ready
  );

  // The unpacker itself
  modport slave (
    input  in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser, in_stream_tvalid,
    output in_stream_tready,
    output pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, pix_valid,
    input  pix_ready
  );
endinterface

// File: rtl/video_stream_unpacker.sv
// Unpacks 4 RGB pixels from 3 stream words, tracks x/y and checks SOF/EOL framing.
// Latency: pixel valid the cycle after the accepting edge; 4 pixels per 4 cycles sustained.
// Backpressure: pix_ready low holds the pixel register and drops in_stream_tready.
module video_stream_unpacker #(
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  video_stream_unpacker_if.slave vid,
  output logic                 locked,
  output logic [7:0]           frame_count,
  output logic [ERR_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {HUNT, P0, P1, P2, EMIT3} state_t;

  localparam logic [10:0] X_LAST  = 11'(X_SIZE - 1);
  localparam logic [10:0] X_TLAST = 11'(X_SIZE - 2);
  localparam logic [10:0] Y_LAST  = 11'(Y_SIZE - 1);

  state_t      state, state_nxt, eff;
  logic [10:0] x, y;          // coordinate of the next pixel to emit
  logic [10:0] px_x, px_y;    // coordinate of the pixel emitted this cycle
  logic [23:0] sav, sav_nxt;  // leftover bytes, oldest in [7:0]
  logic [23:0] emit_rgb;
  logic [7:0]  by0, by1, by2, by3;
  logic        tready_int, slot_free, accept, restart, proc, emit;
  logic        tuser_err, eol_expected, early_eol, eol_miss, err;
  logic        tkeep_unused;

  // Every lane is always populated, so tkeep carries no information
  assign tkeep_unused = ^vid.in_stream_tkeep;

  assign {by3, by2, by1, by0} = vid.in_stream_tdata;
  assign slot_free = !vid.pix_valid || vid.pix_ready;
  assign vid.in_stream_tready = tready_int && aresetn;
  assign accept  = vid.in_stream_tvalid && vid.in_stream_tready;
  // Any accepted tuser word starts a frame; it is processed as P0 at (0,0)
  assign restart = accept && vid.in_stream_tuser;
  assign proc    = accept && (state != HUNT || restart);
  assign eff     = restart ? P0 : state;

  assign tuser_err    = restart && state != HUNT && !(state == P0 && x == '0 && y == '0);
  assign eol_expected = proc && eff == P2 && x == X_TLAST;
  assign early_eol    = proc && vid.in_stream_tlast && !eol_expected;
  assign eol_miss     = eol_expected && !vid.in_stream_tlast;
  assign err          = tuser_err || early_eol || eol_miss;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= HUNT;
    else          state <= state_nxt;
  end

  // Next state: advance per accepted word, early EOL skips EMIT3
  always_comb begin
    state_nxt = state;
    if (proc) begin
      case (eff)
        P0:      state_nxt = P1;
        P1:      state_nxt = P2;
        P2:      state_nxt = EMIT3;
        default: state_nxt = state;
      endcase
      if (early_eol) state_nxt = P0;
    end else if (state == EMIT3 && slot_free) begin
      state_nxt = P0;
    end
  end

  // FSM output: input ready, held low while the fourth pixel drains
  always_comb begin
    tready_int = 1'b0;
    case (state)
      HUNT:       tready_int = 1'b1;
      P0, P1, P2: tready_int = slot_free;
      default:    tready_int = 1'b0;
    endcase
  end

  // Pixel assembly from the current word and the saved bytes
  always_comb begin
    emit     = 1'b0;
    emit_rgb = '0;
    sav_nxt  = sav;
    px_x     = restart ? 11'd0 : x;
    px_y     = restart ? 11'd0 : y;
    if (proc) begin
      emit = 1'b1;
      case (eff)
        P0: begin
          emit_rgb = {by0, by1, by2};
          sav_nxt  = {sav[23:8], by3};
        end
        P1: begin
          emit_rgb = {sav[7:0], by0, by1};
          sav_nxt  = {sav[23:16], by3, by2};
        end
        P2: begin
          emit_rgb = {sav[7:0], sav[15:8], by0};
          sav_nxt  = {by3, by2, by1};
        end
        default: emit_rgb = '0;
      endcase
    end else if (state == EMIT3 && slot_free) begin
      emit     = 1'b1;
      emit_rgb = {sav[7:0], sav[15:8], sav[23:16]};
    end
  end

  // Pixel register, coordinates and saved bytes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vid.pix_r     <= '0;
      vid.pix_g     <= '0;
      vid.pix_b     <= '0;
      vid.pix_x     <= '0;
      vid.pix_y     <= '0;
      vid.pix_sof   <= 1'b0;
      vid.pix_eol   <= 1'b0;
      vid.pix_valid <= 1'b0;
      x             <= '0;
      y             <= '0;
      sav           <= '0;
    end else begin
      sav <= sav_nxt;
      if (emit) begin
        vid.pix_r     <= emit_rgb[23:16];
        vid.pix_g     <= emit_rgb[15:8];
        vid.pix_b     <= emit_rgb[7:0];
        vid.pix_x     <= px_x;
        vid.pix_y     <= px_y;
        vid.pix_sof   <= (px_x == '0) && (px_y == '0);
        vid.pix_eol   <= (px_x == X_LAST);
        vid.pix_valid <= 1'b1;
        if (early_eol || px_x == X_LAST) begin
          x <= '0;
          y <= (px_y == Y_LAST) ? 11'd0 : px_y + 11'd1;
        end else begin
          x <= px_x + 11'd1;
          y <= px_y;
        end
      end else if (vid.pix_ready) begin
        vid.pix_valid <= 1'b0;
      end
    end
  end

  // Lock, frame and saturating error counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      locked      <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (restart) begin
        locked      <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end
      if (err && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_video_stream_unpacker.sv
// Directed bench for video_stream_unpacker with an 8x2 frame and a 2-bit error counter.
// Pixels are captured on the falling edge whenever pix_valid and pix_ready are both high.
// Expected pixels come from the byte-layout rule applied to a known byte sequence.
module tb_video_stream_unpacker;
  localparam int XS = 8;
  localparam int YS = 2;
  localparam int EW = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          locked;
  logic [7:0]    frame_count;
  logic [EW-1:0] err_count;

  video_stream_unpacker_if vif();

  video_stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS), .ERR_WIDTH(EW)) dut (
    .aclk(aclk), .aresetn(aresetn), .vid(vif),
    .locked(locked), .frame_count(frame_count), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  logic [47:0] cap [0:255];
  int cap_n = 0;
  int rd = 0;
  int tready_low = 0;
  int t0;
  logic [47:0] snap;
  wire  [47:0] pix_now = {vif.pix_r, vif.pix_g, vif.pix_b, vif.pix_x, vif.pix_y, vif.pix_sof, vif.pix_eol};

  // Capture transferred pixels and count stalled-input cycles
  always @(negedge aclk) begin
    if (vif.pix_valid && vif.pix_ready && cap_n < 256) begin
      cap[cap_n] <= pix_now;
      cap_n <= cap_n + 1;
    end
    if (aresetn && !vif.in_stream_tready) tready_low <= tready_low + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bv(input int i);
    return 8'((i + 1) * 17);
  endfunction

  function automatic logic [31:0] wd(input int k);
    return {bv(4*k+3), bv(4*k+2), bv(4*k+1), bv(4*k)};
  endfunction

  function automatic logic [47:0] px(input int b, input int x, input int y);
    return {bv(b), bv(b+1), bv(b+2), 11'(x), 11'(y), (x == 0 && y == 0), (x == XS-1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic u, input logic l);
    logic ok;
    vif.in_stream_tdata  = d;
    vif.in_stream_tuser  = u;
    vif.in_stream_tlast  = l;
    vif.in_stream_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge aclk);
      if (vif.in_stream_tready) ok = 1'b1;
      @(posedge aclk);
      #1;
    end
    vif.in_stream_tvalid = 1'b0;
    chk("word_accepted", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic chk_pix(input string tag, input logic [47:0] e);
    chk({tag, "_present"}, 64'(rd < cap_n), 64'd1);
    if (rd < cap_n) begin
      chk(tag, 64'(cap[rd]), 64'(e));
      rd++;
    end
  endtask

  initial begin
    vif.in_stream_tdata  = '0;
    vif.in_stream_tkeep  = 4'hF;
    vif.in_stream_tlast  = 1'b0;
    vif.in_stream_tuser  = 1'b0;
    vif.in_stream_tvalid = 1'b0;
    vif.pix_ready        = 1'b1;

    // Reset state
    #12;
    chk("rst_tready", 64'(vif.in_stream_tready), 64'd0);
    chk("rst_pix", 64'({vif.pix_valid, pix_now}), 64'd0);
    chk("rst_status", 64'({locked, frame_count, err_count}), 64'd0);
    @(negedge aclk) aresetn = 1'b1;
    idle(1);
    chk("rel_tready", 64'(vif.in_stream_tready), 64'd1);
    chk("rel_locked", 64'(locked), 64'd0);

    // Basic unpack and full frame
    t0 = tready_low;
    for (int k = 0; k < 12; k++) begin
      send(wd(k), k == 0, k == 5 || k == 11);
      if (k == 0) begin
        chk("lat_valid", 64'(vif.pix_valid), 64'd1);
        chk("lat_rgb", 64'({vif.pix_r, vif.pix_g, vif.pix_b}), 64'h112233);
        chk("lat_sof", 64'(vif.pix_sof), 64'd1);
      end
    end
    idle(3);
    chk("emit3_tready_low", 64'(tready_low - t0), 64'd4);
    chk_pix("px0", {24'h112233, 11'd0, 11'd0, 1'b1, 1'b0});
    chk_pix("px1", {24'h445566, 11'd1, 11'd0, 1'b0, 1'b0});
    chk_pix("px2", {24'h778899, 11'd2, 11'd0, 1'b0, 1'b0});
    chk_pix("px3", {24'hAABBCC, 11'd3, 11'd0, 1'b0, 1'b0});
    for (int n = 4; n < 16; n++) chk_pix($sformatf("full_px%0d", n), px(3*n, n % XS, n / XS));
    chk("full_err", 64'(err_count), 64'd0);
    chk("full_frames", 64'(frame_count), 64'd1);
    chk("full_locked", 64'(locked), 64'd1);

    // Backpressure: five stalled cycles mid-line
    fork
      begin
        for (int k = 0; k < 12; k++) send(wd(k), k == 0, k == 5 || k == 11);
      end
      begin
        repeat (3) @(posedge aclk);
        #1 vif.pix_ready = 1'b0;
        @(negedge aclk);
        snap = pix_now;
        chk("stall_valid", 64'(vif.pix_valid), 64'd1);
        chk("stall_tready", 64'(vif.in_stream_tready), 64'd0);
        repeat (4) begin
          @(negedge aclk);
          chk("stall_hold", 64'(pix_now), 64'(snap));
          chk("stall_tready", 64'(vif.in_stream_tready), 64'd0);
        end
        @(posedge aclk);
        #1 vif.pix_ready = 1'b1;
      end
    join
    idle(3);
    for (int n = 0; n < 16; n++) chk_pix($sformatf("bp_px%0d", n), px(3*n, n % XS, n / XS));
    chk("bp_err", 64'(err_count), 64'd0);
    chk("bp_frames", 64'(frame_count), 64'd2);

    // Early tlast on the third word of a line
    send(wd(0), 1'b1, 1'b0);
    send(wd(1), 1'b0, 1'b0);
    send(wd(2), 1'b0, 1'b1);
    idle(2);
    chk("eol_err", 64'(err_count), 64'd1);
    chk_pix("eol_px0", px(0, 0, 0));
    chk_pix("eol_px1", px(3, 1, 0));
    chk_pix("eol_px2", px(6, 2, 0));
    send(wd(3), 1'b0, 1'b0);
    idle(2);
    chk_pix("eol_next", px(12, 0, 1));
    chk("eol_frames", 64'(frame_count), 64'd3);

    // tuser arriving mid-line restarts the frame
    send(wd(0), 1'b1, 1'b0);
    idle(2);
    chk("sof_err", 64'(err_count), 64'd2);
    chk_pix("sof_px", px(0, 0, 0));
    chk("sof_frames", 64'(frame_count), 64'd4);

    // Reset mid-frame with a word pending
    vif.in_stream_tdata  = wd(1);
    vif.in_stream_tuser  = 1'b0;
    vif.in_stream_tlast  = 1'b0;
    vif.in_stream_tvalid = 1'b1;
    #3 aresetn = 1'b0;
    #1;
    chk("mid_rst_tready", 64'(vif.in_stream_tready), 64'd0);
    chk("mid_rst_pix", 64'({vif.pix_valid, pix_now}), 64'd0);
    chk("mid_rst_status", 64'({locked, frame_count, err_count}), 64'd0);
    vif.in_stream_tvalid = 1'b0;
    @(negedge aclk) aresetn = 1'b1;
    idle(1);
    rd = cap_n;
    chk("mid_rel_tready", 64'(vif.in_stream_tready), 64'd1);
    send(wd(1), 1'b0, 1'b0);
    idle(3);
    chk("hunt_no_pix", 64'(cap_n - rd), 64'd0);
    chk("hunt_locked", 64'(locked), 64'd0);

    // Error counter saturation
    send(wd(0), 1'b1, 1'b0);
    chk("sat_start", 64'(err_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      send(wd(0), 1'b1, 1'b0);
      if (i == 1) chk("sat_two", 64'(err_count), 64'd2);
    end
    chk("sat_err", 64'(err_count), 64'd3);
    chk("sat_frames", 64'(frame_count), 64'd6);
    chk("sat_locked", 64'(locked), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
